slave_spi_receiver: RTL and testbench
=====================================

// Module: slave_spi_receiver
// PURPOSE
// - Serial-to-parallel receive end of the node-to-node link; the other end of the link is the master SPI transmitter.
// - Deserialises one instruction frame (CS / SCLK / data line from a neighbour) into a WIDTH-bit word.
// - Presents the word to the receiver queue with a valid/ready handshake.
// - One instance per inbound port (left, right, self). All link inputs are asynchronous to clk and are synchronised internally.
// PARAMETERS
// - WIDTH        32  instruction word width in bits; MSB is shifted in first
// - SYNC_STAGES  2   flip-flop synchroniser depth on spi_sclk / spi_cs / spi_mosi; legal values >= 2
// PORTS
// - clk        in   1      system clock; all state on rising edge
// - rst_n      in   1      asynchronous active-low reset
// - spi_sclk   in   1      link serial clock from the neighbour; data is sampled on its rising edge
// - spi_cs     in   1      link chip-select, active HIGH; frames one word
// - spi_mosi   in   1      link serial data
// - out_data   out  WIDTH  received word; stable while out_valid=1
// - out_valid  out  1      word available to the receiver queue
// - out_ready  in   1      queue accepts the word when out_valid & out_ready
// - err_clr    in   1      one-cycle pulse; clears the sticky overrun flag
// - overrun    out  1      sticky flag: a completed word was dropped because out_valid was still held
// - frame_err  out  1      one-cycle pulse: CS dropped after 1..WIDTH-1 bits
// - parity_err out  1      one-cycle pulse: parity mismatch (tied 0 when the parity feature is compiled out)
// BEHAVIOUR
// - Reset values: out_data=0, out_valid=0, overrun=0, frame_err=0, parity_err=0, bit counter=0.
//   Synchroniser chains reset to 0; FSM resets to WAIT_IDLE.
// - Sampling: edges are detected on the synchronised signals only.
//   spi_sclk high and low times must each be >= 2 clk periods; faster SCLK is unsupported.
// - FSM states:
//   - WAIT_IDLE: leave to IDLE once synced CS=0. This stops a reset that releases mid-frame from capturing a partial frame.
//   - IDLE: on synced CS 0->1, clear the counter and go to SHIFT.
//   - SHIFT: on each synced SCLK rising edge, shreg <= {shreg, mosi} and cnt++.
//     - When cnt reaches FRAME_BITS (WIDTH, or WIDTH+1 with parity), go to DONE and commit.
//     - CS 1->0 with 0 < cnt < FRAME_BITS: frame_err=1 for one cycle, word discarded, go to IDLE.
//     - CS 1->0 with cnt=0: go to IDLE silently.
//   - DONE: further SCLK edges are ignored; CS 1->0 returns to IDLE.
// - Commit, in the cycle after the final SCLK edge is detected:
//   - If out_valid=0, or out_ready=1 in that cycle: load out_data and set out_valid=1. A simultaneous accept and load keeps out_valid=1 with no bubble and no overrun.
//   - If out_valid=1 and out_ready=0: drop the new word, set overrun=1, leave out_data unchanged.
// - Latency: from the final spi_sclk rising edge at the pin to out_valid=1 is SYNC_STAGES+2 clk.
// - Handshake: out_valid falls in the cycle after out_valid & out_ready unless a new word commits in the same cycle. out_data never changes while out_valid=1 and out_ready=0.
// - Sticky flag: overrun clears only on err_clr or reset. If err_clr and a new overrun event occur in the same cycle, overrun ends at 1.
// - Counter is $clog2(WIDTH+2) bits wide and never wraps: in DONE it saturates at FRAME_BITS.
// CONFIGURATION
// - Macro SLAVE_SPI_PARITY_CHECK_EN.
// - Defined:
//   - Frame is WIDTH+1 bits; the last bit is even parity over the WIDTH data bits.
//   - On mismatch: the word is not committed, parity_err pulses for one cycle, and overrun is not affected.
// - Undefined:
//   - Frame is exactly WIDTH bits, and parity_err is driven to constant 0.
//   - Port list is identical in both builds.
// TESTING
// - Reset then one 32-bit frame 0xA5C3_0F1E with SCLK = clk/8 -> out_valid=1 exactly SYNC_STAGES+2 clk after the last edge, out_data=0xA5C3_0F1E, no errors.
// - out_ready held 0, two back-to-back frames 0x1111_1111 then 0x2222_2222 -> out_data stays 0x1111_1111 and overrun=1. err_clr pulse -> overrun=0.
// - out_ready asserted in the same cycle the second word commits -> first word accepted, out_data=0x2222_2222, out_valid stays 1, overrun=0.
// - CS dropped after 17 bits -> one frame_err pulse, out_valid stays 0. The next full frame 0xDEAD_BEEF is received correctly.
// - rst_n asserted mid-frame (bit 10) and released with CS still high -> nothing captured until CS falls; a subsequent full frame is received correctly.
// - With SLAVE_SPI_PARITY_CHECK_EN: frame 0x0000_0001 with parity bit 1 -> committed. Same frame with parity bit 0 -> parity_err pulse, nothing committed.

Source files
------------

// File: rtl/slave_spi_receiver.sv
// Slave SPI receiver: synchronises an async CS/SCLK/MOSI link, deserialises one MSB-first frame
// and offers the word with valid/ready. Define SLAVE_SPI_PARITY_CHECK_EN to add a trailing even-parity bit.
module slave_spi_receiver #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sclk,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef SLAVE_SPI_PARITY_CHECK_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = WIDTH + PAR_BITS;
  localparam int CW         = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SETTLE_CNT = CW'(SYNC_STAGES);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic                        r_sclk_q;
  logic                        r_cs_q;
  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic [FRAME_BITS-1:0]       r_shreg;
  logic                        r_commit;
  logic                        r_frame_err;
  logic [WIDTH-1:0]            r_out_data;
  logic                        r_out_valid;
  logic                        r_overrun;

  logic w_sclk, w_cs, w_mosi;
  logic w_sclk_rise, w_cs_rise, w_cs_fall;
  logic w_par_ok, w_load, w_drop;
  logic [WIDTH-1:0] w_word;

  assign w_sclk      = r_sync[SYNC_STAGES-1][2];
  assign w_cs        = r_sync[SYNC_STAGES-1][1];
  assign w_mosi      = r_sync[SYNC_STAGES-1][0];
  assign w_sclk_rise = w_sclk & ~r_sclk_q;
  assign w_cs_rise   = w_cs & ~r_cs_q;
  assign w_cs_fall   = ~w_cs & r_cs_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sclk_q <= 1'b0;
      r_cs_q   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], {spi_sclk, spi_cs, spi_mosi}};
      r_sclk_q <= w_sclk;
      r_cs_q   <= w_cs;
    end
  end

  // In WAIT_IDLE the counter first lets the reset-zeroed synchronisers fill with real pin values,
  // so a CS that was already high at reset release is not mistaken for idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (r_cnt < SETTLE_CNT) begin
            r_cnt <= r_cnt + CNT_ONE;
          end else if (!w_cs) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_cs_rise) begin
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_cs_fall) begin
            r_frame_err <= (r_cnt != '0);
            r_state     <= IDLE;
          end else if (w_sclk_rise) begin
            r_shreg <= {r_shreg[FRAME_BITS-2:0], w_mosi};
            r_cnt   <= r_cnt + CNT_ONE;
            if (r_cnt == LAST_CNT) begin
              r_commit <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          if (w_cs_fall) r_state <= IDLE;
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign w_word = r_shreg[FRAME_BITS-1 -: WIDTH];

`ifdef SLAVE_SPI_PARITY_CHECK_EN
  logic r_parity_err;

  // Data plus parity bit must XOR to zero for even parity.
  assign w_par_ok = ~(^r_shreg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= r_commit & ~w_par_ok;
  end

  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign w_load = r_commit & w_par_ok & (~r_out_valid | out_ready);
  assign w_drop = r_commit & w_par_ok & r_out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop)       r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_slave_spi_receiver.sv
// Directed + randomized bench for slave_spi_receiver; expected outputs come from a small
// transaction-level model of the handshake/overrun rules. Honours SLAVE_SPI_PARITY_CHECK_EN.
module tb_slave_spi_receiver;
  localparam int WIDTH = 32;
  localparam int SS    = 2;
`ifdef SLAVE_SPI_PARITY_CHECK_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             spi_sclk, spi_cs, spi_mosi;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready, err_clr;
  logic             overrun, frame_err, parity_err;

  slave_spi_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_clr(err_clr), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int fe_exp   = 0;
  int pe_exp   = 0;

  always @(posedge clk) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
  end

  // Reference model: the word on offer, whether it is on offer, and the sticky overrun flag.
  logic [WIDTH-1:0] exp_data;
  bit               exp_valid;
  bit               exp_overrun;

  task automatic model_reset();
    exp_data = '0; exp_valid = 0; exp_overrun = 0;
  endtask

  task automatic model_frame(input logic [WIDTH-1:0] w, input bit ready_at_commit);
    if (!exp_valid || ready_at_commit) begin
      exp_data  = w;
      exp_valid = 1;
    end else begin
      exp_overrun = 1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"},   64'(out_valid), 64'(exp_valid));
    check({tag, "_data"},    64'(out_data),  64'(exp_data));
    check({tag, "_overrun"}, 64'(overrun),   64'(exp_overrun));
  endtask

  function automatic logic [63:0] frame_of(input logic [WIDTH-1:0] w, input bit good_par);
`ifdef SLAVE_SPI_PARITY_CHECK_EN
    return {31'b0, w, good_par ? ^w : ~^w};
`else
    return {32'b0, w} | 64'(good_par & 1'b0);
`endif
  endfunction

  task automatic cs_start();
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Shifts bits n-1..0 of f MSB first, SCLK = clk/8; returns right after the last rising edge.
  task automatic shift_bits(input logic [63:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = f[i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      if (i != 0) repeat (4) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (2) @(negedge clk);
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    cs_start();
    shift_bits(frame_of(w, 1'b1), FB);
    end_frame();
    model_frame(w, 1'b0);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_valid = 0;
    check({tag, "_accept"}, 64'(out_valid), 64'(exp_valid));
  endtask

  logic [WIDTH-1:0] w;
  logic [63:0]      f;

  initial begin
    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs = 1'b0; spi_mosi = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_frame_err",  64'(frame_err),  64'd0);
    check("rst_parity_err", 64'(parity_err), 64'd0);
    check_out("rst");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // First frame, with exact latency from the final SCLK rising edge.
    w = 32'hA5C3_0F1E;
    cs_start();
    shift_bits(frame_of(w, 1'b1), FB);
    repeat (SS + 1) @(negedge clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_exact", 64'(out_valid), 64'd1);
    model_frame(w, 1'b0);
    end_frame();
    check_out("first");
    check("first_fe", 64'(fe_cnt), 64'(fe_exp));
    accept("first");

    // Back-to-back frames without acceptance: second word dropped, overrun sticks.
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    check_out("ovr");
    repeat (5) @(negedge clk);
    check("ovr_sticky", 64'(overrun), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_overrun = 0;
    check_out("errclr");

    // Accept in exactly the cycle the next word commits: no bubble, no overrun.
    w = 32'h2222_2222;
    cs_start();
    shift_bits(frame_of(w, 1'b1), FB);
    repeat (SS + 1) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_frame(w, 1'b1);
    check_out("same_cycle");
    end_frame();
    check_out("same_cycle_hold");
    accept("same_cycle");

    // Randomized words.
    for (int k = 0; k < 4; k++) begin
      send_word($urandom);
      check_out("rand");
      accept("rand");
    end

    // CS dropped after 17 bits: one frame_err pulse, nothing offered.
    cs_start();
    shift_bits(frame_of($urandom, 1'b1) >> (FB - 17), 17);
    end_frame();
    fe_exp++;
    check("short_fe", 64'(fe_cnt), 64'(fe_exp));
    check_out("short");
    send_word(32'hDEAD_BEEF);
    check_out("after_short");
    check("after_short_fe", 64'(fe_cnt), 64'(fe_exp));
    accept("after_short");

    // Reset mid-frame (after bit 10) and release with CS high: rest of frame is ignored.
    w = $urandom;
    f = frame_of(w, 1'b1);
    cs_start();
    shift_bits(f >> (FB - 10), 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    shift_bits(f, FB - 10);
    end_frame();
    check_out("midrst");
    check("midrst_fe", 64'(fe_cnt), 64'(fe_exp));
    send_word($urandom);
    check_out("after_midrst");
    accept("after_midrst");

`ifdef SLAVE_SPI_PARITY_CHECK_EN
    cs_start();
    shift_bits(frame_of(32'h0000_0001, 1'b1), FB);
    end_frame();
    model_frame(32'h0000_0001, 1'b0);
    check_out("par_good");
    accept("par_good");
    cs_start();
    shift_bits(frame_of(32'h0000_0001, 1'b0), FB);
    end_frame();
    pe_exp++;
    check_out("par_bad");
`endif
    check("parity_pulses", 64'(pe_cnt), 64'(pe_exp));
    check("frame_pulses",  64'(fe_cnt), 64'(fe_exp));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
